// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, WRITE, ACK)
//   - rr_pick_t   : result of a round-robin search (found flag + index)
//   - rr_pick()   : round-robin search over up to MAX_REQ request bits
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    // Upper bound on the number of requesters the helper can handle.
    localparam int MAX_REQ = 8;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    // Search starts at ptr+1 (mod num_req) and wraps, so ptr itself is
    // visited last. With exclude_en set, exclude_id is never chosen.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_IDW-1:0] ptr,
        input logic               exclude_en,
        input logic [MAX_IDW-1:0] exclude_id,
        input int                 num_req
    );
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req && !res.found) begin
                idx = (int'(ptr) + k) % num_req;
                if (req[idx[MAX_IDW-1:0]] &&
                    !(exclude_en && (idx[MAX_IDW-1:0] == exclude_id))) begin
                    res.found = 1'b1;
                    res.idx   = idx[MAX_IDW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_rr_pick
//   Combinational round-robin picker.
//   Ports:
//     req_i        : request vector
//     ptr_i        : last-served index; search begins at ptr_i+1
//     excl_en_i    : when set, excl_id_i is not eligible
//     excl_id_i    : index to exclude
//     found_o      : at least one eligible request
//     idx_o        : winning index (valid when found_o)
// -----------------------------------------------------------------------------
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    input  logic                       excl_en_i,
    input  logic [$clog2(NUM_REQ)-1:0] excl_id_i,
    output logic                       found_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IDW = $clog2(NUM_REQ);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_i), MAX_IDW'(ptr_i), excl_en_i,
                          MAX_IDW'(excl_id_i), NUM_REQ);
        found_o = pick.found;
        idx_o   = IDW'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   Ports:
//     clk, rst_n     : clock (rising edge), async active-low reset
//     req            : per-producer request, held until its done pulse
//     req_data       : packed words, slice i = [i*FIFO_WIDTH +: FIFO_WIDTH]
//     fifo_full      : FIFO full flag (gates issue)
//     fifo_wr_ack    : FIFO registered write acknowledge
//     fifo_overflow  : FIFO registered overflow flag
//     wr_en, data_in : registered FIFO write strobe and data
//     done           : one-hot, one-cycle commit pulse per requester
//     busy           : high while in WRITE or ACK
//     cur_id         : requester currently being served
//     retry_cnt      : saturating count of rejected writes
//
//   Handshake: a producer raises req[i] with stable req_data slice i and
//   holds both until done[i] pulses; done[i] means the FIFO accepted the word.
//   Toward the FIFO, wr_en is a single-cycle strobe and the result is read
//   from fifo_wr_ack / fifo_overflow one cycle later (ACK state).
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int RETRY_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id,
    output logic [RETRY_W-1:0]            retry_cnt
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_e          state_q;
    logic                wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                busy_q;
    logic [IDW-1:0]      cur_id_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [RETRY_W-1:0]  retry_q;
    // Set when a rejected write is waiting in ACK for the FIFO to drain;
    // keeps the retry counter from incrementing once per stalled cycle.
    logic                retry_pend_q;

    logic                pick_found;
    logic [IDW-1:0]      pick_idx;
    logic [IDW-1:0]      pick_ptr_d;
    logic                pick_excl_d;

    // In ACK the commit makes cur_id the new pointer, and cur_id must not be
    // picked again because its req is still visible this cycle.
    always_comb begin
        pick_ptr_d  = rr_ptr_q;
        pick_excl_d = 1'b0;
        if (state_q == ACK) begin
            pick_ptr_d  = cur_id_q;
            pick_excl_d = 1'b1;
        end
    end

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (pick_ptr_d),
        .excl_en_i (pick_excl_d),
        .excl_id_i (cur_id_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            data_q       <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            cur_id_q     <= '0;
            rr_ptr_q     <= IDW'(NUM_REQ - 1);
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_found && !fifo_full) begin
                        cur_id_q <= pick_idx;
                        data_q   <= req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
                        wr_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= WRITE;
                    end else begin
                        wr_en_q  <= 1'b0;
                    end
                end

                WRITE: begin
                    wr_en_q      <= 1'b0;
                    retry_pend_q <= 1'b0;
                    state_q      <= ACK;
                end

                ACK: begin
                    if (retry_pend_q) begin
                        // Retry owns the port until it is re-issued.
                        if (!fifo_full) begin
                            wr_en_q      <= 1'b1;
                            retry_pend_q <= 1'b0;
                            state_q      <= WRITE;
                        end
                    end else if (fifo_wr_ack && !fifo_overflow) begin
                        done_q[cur_id_q] <= 1'b1;
                        rr_ptr_q         <= cur_id_q;
                        if (pick_found && !fifo_full) begin
                            cur_id_q <= pick_idx;
                            data_q   <= req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
                            wr_en_q  <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        if (retry_q != '1) begin
                            retry_q <= retry_q + 1'b1;
                        end
                        if (!fifo_full) begin
                            wr_en_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            retry_pend_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign data_in   = data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cur_id    = cur_id_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with a behavioural 8-deep FIFO that
//   registers wr_ack / overflow and can be told to reject writes.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int RW    = 8;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           fifo_full;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
    logic           wr_en;
    logic [W-1:0]   data_in;
    logic [N-1:0]   done;
    logic           busy;
    logic [1:0]     cur_id;
    logic [RW-1:0]  retry_cnt;

    fifo_wr_arbiter #(
        .FIFO_WIDTH (W),
        .NUM_REQ    (N),
        .RETRY_W    (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .wr_en         (wr_en),
        .data_in       (data_in),
        .done          (done),
        .busy          (busy),
        .cur_id        (cur_id),
        .retry_cnt     (retry_cnt)
    );

    // ---------------- FIFO model ----------------
    logic       rd_en;
    logic       force_ovf;
    int         fifo_cnt;
    int         ovf_n;
    logic       push;
    logic       pop;
    logic [W-1:0] mem[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ack   <= 1'b0;
            fifo_overflow <= 1'b0;
            fifo_cnt      <= 0;
            ovf_n         = 0;
            mem.delete();
        end else begin
            fifo_wr_ack   <= 1'b0;
            fifo_overflow <= 1'b0;
            push = wr_en && !force_ovf && (fifo_cnt < DEPTH);
            pop  = rd_en && (fifo_cnt > 0);
            if (wr_en) begin
                if (push) begin
                    mem.push_back(data_in);
                    fifo_wr_ack <= 1'b1;
                end else begin
                    fifo_overflow <= 1'b1;
                    ovf_n = ovf_n + 1;
                end
            end
            if (pop) void'(mem.pop_front());
            fifo_cnt <= fifo_cnt + int'(push) - int'(pop);
        end
    end

    assign fifo_full = (fifo_cnt == DEPTH);

    // ---------------- done monitor ----------------
    int         cyc = 0;
    logic [N-1:0] done_log[$];
    int         done_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done != '0) begin
            done_log.push_back(done);
            done_cyc.push_back(cyc);
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        rd_en     = 1'b0;
        force_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input logic [N-1:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != '0) break;
        end
        check(tag, 32'(done), 32'(exp));
    endtask

    task automatic wait_ovf(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ovf_n >= target) break;
        end
        check(tag, 32'(ovf_n >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int start;
        req       = '0;
        req_data  = '0;
        rd_en     = 1'b0;
        force_ovf = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_wr_en",   32'(wr_en),     32'd0);
        check("rst_data_in", 32'(data_in),   32'd0);
        check("rst_done",    32'(done),      32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_cur_id",  32'(cur_id),    32'd0);
        check("rst_retry",   32'(retry_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single request, done two cycles after wr_en
        req_data[15:0] = 16'hA5A5;
        req = 4'b0001;
        @(negedge clk);
        check("t1_wr_en",   32'(wr_en),   32'd1);
        check("t1_data",    32'(data_in), 32'hA5A5);
        check("t1_cur_id",  32'(cur_id),  32'd0);
        check("t1_busy",    32'(busy),    32'd1);
        check("t1_done_w",  32'(done),    32'd0);
        @(negedge clk);
        check("t1_wr_en_off", 32'(wr_en), 32'd0);
        check("t1_done_a",  32'(done),    32'd0);
        @(negedge clk);
        check("t1_done",    32'(done),    32'b0001);
        check("t1_retry",   32'(retry_cnt), 32'd0);
        req = '0;
        @(negedge clk);
        check("t1_done_end", 32'(done),   32'd0);
        check("t1_busy_end", 32'(busy),   32'd0);
        do_reset();

        // 2: all requesters, round-robin order, one done per 2 cycles
        req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        start = done_log.size();
        req = 4'b1111;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_log.size() - start >= DEPTH) break;
        end
        check("t2_n_done", 32'(done_log.size() - start), 32'(DEPTH));
        for (int k = 0; k < DEPTH && (start + k) < done_log.size(); k++) begin
            check($sformatf("t2_order%0d", k), 32'(done_log[start+k]), 32'(1 << (k % N)));
            if (k > 0)
                check($sformatf("t2_gap%0d", k),
                      32'(done_cyc[start+k] - done_cyc[start+k-1]), 32'd2);
        end
        check("t2_fifo_size", 32'(mem.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < mem.size(); k++)
            check($sformatf("t2_fifo%0d", k), 32'(mem[k]), 32'h1000 + 32'(k % N));

        // 3: FIFO full stalls; one read lets requester 1 through
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_wr_en_full", 32'(wr_en), 32'd0);
            check("t3_busy_full",  32'(busy),  32'd0);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t3_wr_en_rd", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("t3_wr_en",  32'(wr_en),   32'd1);
        check("t3_cur_id", 32'(cur_id),  32'd1);
        check("t3_data",   32'(data_in), 32'h1001);
        wait_done("t3_done", 4'b0010, 4);
        req = '0;
        do_reset();

        // 4: forced overflow, retry of the same word
        req_data[47:32] = 16'hBEEF;
        force_ovf = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        check("t4_wr_en",   32'(wr_en),  32'd1);
        check("t4_cur_id",  32'(cur_id), 32'd2);
        @(negedge clk);
        force_ovf = 1'b0;
        check("t4_retry0",  32'(retry_cnt), 32'd0);
        @(negedge clk);
        check("t4_retry1",  32'(retry_cnt), 32'd1);
        check("t4_rewr",    32'(wr_en),     32'd1);
        check("t4_redata",  32'(data_in),   32'hBEEF);
        check("t4_recur",   32'(cur_id),    32'd2);
        check("t4_nodone",  32'(done),      32'd0);
        @(negedge clk);
        check("t4_nodone2", 32'(done),      32'd0);
        @(negedge clk);
        check("t4_done",    32'(done),      32'b0100);
        req = '0;
        do_reset();

        // 5: async reset during WRITE, requester 0 wins afterwards
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'hD000};
        req = 4'b1000;
        @(negedge clk);
        check("t5_wr_en",   32'(wr_en),  32'd1);
        check("t5_cur_id",  32'(cur_id), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en", 32'(wr_en),   32'd0);
        check("t5_rst_busy",  32'(busy),    32'd0);
        check("t5_rst_cur",   32'(cur_id),  32'd0);
        check("t5_rst_data",  32'(data_in), 32'd0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_win0",    32'(cur_id),  32'd0);
        check("t5_data0",   32'(data_in), 32'hD000);
        wait_done("t5_done0", 4'b0001, 6);
        req = 4'b1000;
        wait_done("t5_done3", 4'b1000, 8);
        req = '0;
        do_reset();

        // 6: retry counter saturation
        force_ovf = 1'b1;
        req = 4'b0001;
        wait_ovf("t6_reach100", 100, 400);
        @(negedge clk);
        check("t6_retry100", 32'(retry_cnt), 32'd100);
        wait_ovf("t6_reach300", 300, 600);
        repeat (2) @(negedge clk);
        check("t6_sat",      32'(retry_cnt), 32'hFF);
        check("t6_busy",     32'(busy),      32'd1);
        force_ovf = 1'b0;
        wait_done("t6_done", 4'b0001, 8);
        check("t6_sat_end",  32'(retry_cnt), 32'hFF);
        req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
